line_buffer_feeder: RTL and testbench

//  Source side of line_buffer. Reads a feature map from row-banked feature RAM and drives line_buffer's data_in, enable,

---
 rtl/line_buffer_feeder_pkg.sv | 24 ++
 rtl/lb_feed_addr_gen.sv | 38 +++
 rtl/line_buffer_feeder.sv | 175 +++++++++++++++++
 tb/tb_line_buffer_feeder.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_buffer_feeder_pkg.sv
// Shared types and constants for the line_buffer source-side feeder.
// Mode encodings match line_buffer.line_buffer_mod.
package line_buffer_feeder_pkg;

   localparam int FEATURE_WIDTH = 8;
   localparam int KERNEL_SIZE   = 5;

   localparam logic LB_MODE_FILL   = 1'b0;
   localparam logic LB_MODE_STREAM = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CHECK  = 3'd1,
      ST_FILL   = 3'd2,
      ST_STREAM = 3'd3,
      ST_DRAIN  = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

   function automatic logic kernel_supported(input logic [2:0] k);
      return (k == 3'd3) || (k == 3'd5);
   endfunction

endpackage

// File: rtl/lb_feed_addr_gen.sv
// Row/column read-address counters: column wraps W-1 -> 0 and bumps the row.
// Moves only on an issued read; load restarts at a given row, column 0.
module lb_feed_addr_gen #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [ADDR_WIDTH-1:0] load_row,
   input  logic                  advance,
   input  logic [ADDR_WIDTH-1:0] width,
   output logic [ADDR_WIDTH-1:0] row,
   output logic [ADDR_WIDTH-1:0] col,
   output logic                  col_end
);

   localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   assign col_end = (col == width - ONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         row <= '0;
         col <= '0;
      end else if (load) begin
         row <= load_row;
         col <= '0;
      end else if (advance) begin
         if (col_end) begin
            col <= '0;
            row <= row + ONE;
         end else begin
            col <= col + ONE;
         end
      end
   end

endmodule

// File: rtl/line_buffer_feeder.sv
// Feeds line_buffer from row-banked feature RAM: k-1 rows filled in parallel, then one row per line.
// Read-to-lb_data_in latency 2; stall blocks new reads only (2 beats in flight). Optional LB_FEEDER_STATS_EN adds stat_win_cnt.
module line_buffer_feeder
   import line_buffer_feeder_pkg::*;
#(
   parameter int DATA_WIDTH  = FEATURE_WIDTH,
   parameter int KERNEL_SIZE = line_buffer_feeder_pkg::KERNEL_SIZE,
   parameter int ADDR_WIDTH  = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic [2:0]                        cfg_kernel_size,
   input  logic [ADDR_WIDTH-1:0]             cfg_fm_width,
   input  logic [ADDR_WIDTH-1:0]             cfg_fm_height,
   input  logic                              stall,
   output logic                              fm_rd_en,
   output logic [ADDR_WIDTH-1:0]             fm_rd_row,
   output logic [ADDR_WIDTH-1:0]             fm_rd_col,
   input  logic [DATA_WIDTH*KERNEL_SIZE-1:0] fm_rd_data,
   output logic                              lb_enable,
   output logic                              lb_mode,
   output logic [2:0]                        lb_kernel_size,
   output logic [7:0]                        lb_depth,
   output logic [DATA_WIDTH*KERNEL_SIZE-1:0] lb_data_in,
   output logic                              col_valid,
   output logic                              col_last,
   output logic                              busy,
   output logic                              done,
`ifdef LB_FEEDER_STATS_EN
   output logic [15:0]                       stat_win_cnt,
`endif
   output logic                              cfg_err
);

   localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   state_t state, state_nxt;

   logic [2:0]            cfg_k;
   logic [ADDR_WIDTH-1:0] cfg_w;
   logic [ADDR_WIDTH-1:0] cfg_h;
   logic                  cfg_bad;
   logic                  start_acc;

   logic                  issue;
   logic                  addr_load;
   logic [ADDR_WIDTH-1:0] addr_load_row;
   logic [ADDR_WIDTH-1:0] row;
   logic [ADDR_WIDTH-1:0] col;
   logic                  col_end;

   logic                  s1_vld;
   logic                  s1_mode;
   logic                  s1_last;
   logic                  lb_last;
   logic [DATA_WIDTH*KERNEL_SIZE-1:0] mapped;

   // The top RAM slot is never needed: fill uses k-1 rows at most, stream only slot 0.
   logic unused_top_slot;
   assign unused_top_slot = ^fm_rd_data[(KERNEL_SIZE-1)*DATA_WIDTH +: DATA_WIDTH];

   assign start_acc = start && (state == ST_IDLE);
   assign cfg_bad   = !kernel_supported(cfg_k) || (cfg_w == '0) ||
                      (cfg_h < ADDR_WIDTH'(cfg_k));

   lb_feed_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_addr_gen (
      .clk      (clk),
      .rst      (rst),
      .load     (addr_load),
      .load_row (addr_load_row),
      .advance  (issue),
      .width    (cfg_w),
      .row      (row),
      .col      (col),
      .col_end  (col_end)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (start) state_nxt = ST_CHECK;
         ST_CHECK:  state_nxt = cfg_bad ? ST_DONE : ST_FILL;
         ST_FILL:   if (issue && col_end) state_nxt = ST_STREAM;
         ST_STREAM: if (issue && col_end && (row == cfg_h - ONE)) state_nxt = ST_DRAIN;
         ST_DRAIN:  if (!s1_vld) state_nxt = ST_DONE;
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy          = (state != ST_IDLE);
      done          = (state == ST_DONE);
      issue         = ((state == ST_FILL) || (state == ST_STREAM)) && !stall;
      fm_rd_en      = issue;
      fm_rd_row     = issue ? row : '0;
      fm_rd_col     = issue ? col : '0;
      // Fill ends by jumping straight to the first row that is not yet buffered.
      addr_load     = (state == ST_CHECK) || ((state == ST_FILL) && issue && col_end);
      addr_load_row = (state == ST_FILL) ? ADDR_WIDTH'(cfg_k) - ONE : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_k          <= '0;
         cfg_w          <= '0;
         cfg_h          <= '0;
         cfg_err        <= 1'b0;
         lb_kernel_size <= '0;
         lb_depth       <= '0;
      end else if (start_acc) begin
         cfg_k   <= cfg_kernel_size;
         cfg_w   <= cfg_fm_width;
         cfg_h   <= cfg_fm_height;
         cfg_err <= 1'b0;
      end else if (state == ST_CHECK) begin
         cfg_err        <= cfg_bad;
         lb_kernel_size <= cfg_k;
         lb_depth       <= 8'(cfg_w - ONE);
      end
   end

   always_comb begin
      mapped = '0;
      if (s1_mode == LB_MODE_STREAM) begin
         mapped[0 +: DATA_WIDTH] = fm_rd_data[0 +: DATA_WIDTH];
      end else begin
         for (int j = 0; j < KERNEL_SIZE - 1; j++) begin
            if (j + 1 < int'(lb_kernel_size))
               mapped[(j+1)*DATA_WIDTH +: DATA_WIDTH] = fm_rd_data[j*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld     <= 1'b0;
         s1_mode    <= LB_MODE_FILL;
         s1_last    <= 1'b0;
         lb_enable  <= 1'b0;
         lb_mode    <= LB_MODE_FILL;
         lb_last    <= 1'b0;
         lb_data_in <= '0;
      end else begin
         s1_vld     <= issue;
         s1_mode    <= (state == ST_STREAM) ? LB_MODE_STREAM : LB_MODE_FILL;
         s1_last    <= col_end;
         lb_enable  <= s1_vld;
         lb_mode    <= s1_mode;
         lb_last    <= s1_last;
         lb_data_in <= s1_vld ? mapped : '0;
      end
   end

   assign col_valid = lb_enable && (lb_mode == LB_MODE_STREAM);
   assign col_last  = col_valid && lb_last;

`ifdef LB_FEEDER_STATS_EN
   always_ff @(posedge clk) begin
      if (rst || start_acc)
         stat_win_cnt <= '0;
      else if (col_valid && (stat_win_cnt != 16'hFFFF))
         stat_win_cnt <= stat_win_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_line_buffer_feeder.sv
// Scoreboarded bench for line_buffer_feeder: expected beats are built from the configuration, observed beats are captured on lb_enable.
module tb_line_buffer_feeder;
   import line_buffer_feeder_pkg::*;

   localparam int DW = FEATURE_WIDTH;
   localparam int KS = KERNEL_SIZE;
   localparam int AW = 8;

   logic clk = 1'b0;
   logic rst, start, stall;
   logic [2:0]      cfg_kernel_size;
   logic [AW-1:0]   cfg_fm_width, cfg_fm_height;
   logic            fm_rd_en;
   logic [AW-1:0]   fm_rd_row, fm_rd_col;
   logic [DW*KS-1:0] fm_rd_data;
   logic            lb_enable, lb_mode;
   logic [2:0]      lb_kernel_size;
   logic [7:0]      lb_depth;
   logic [DW*KS-1:0] lb_data_in;
   logic            col_valid, col_last, busy, done, cfg_err;
`ifdef LB_FEEDER_STATS_EN
   logic [15:0]     stat_win_cnt;
`endif

   typedef struct packed {
      logic [DW*KS-1:0] data;
      logic             mode;
      logic             cv;
      logic             cl;
   } beat_t;

   beat_t got_q[$];
   beat_t exp_q[$];
   int rd_cnt = 0;
   int done_cnt = 0;
   int checks = 0;
   int errors = 0;

   line_buffer_feeder dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .cfg_kernel_size (cfg_kernel_size),
      .cfg_fm_width    (cfg_fm_width),
      .cfg_fm_height   (cfg_fm_height),
      .stall           (stall),
      .fm_rd_en        (fm_rd_en),
      .fm_rd_row       (fm_rd_row),
      .fm_rd_col       (fm_rd_col),
      .fm_rd_data      (fm_rd_data),
      .lb_enable       (lb_enable),
      .lb_mode         (lb_mode),
      .lb_kernel_size  (lb_kernel_size),
      .lb_depth        (lb_depth),
      .lb_data_in      (lb_data_in),
      .col_valid       (col_valid),
      .col_last        (col_last),
      .busy            (busy),
      .done            (done),
`ifdef LB_FEEDER_STATS_EN
      .stat_win_cnt    (stat_win_cnt),
`endif
      .cfg_err         (cfg_err)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] fm_val(input int r, input int c);
      return DW'((r * 29 + c * 7 + 3) & 255);
   endfunction

   // Row-banked feature RAM: slot j returns row base+j one cycle after the strobe.
   always @(posedge clk) begin
      if (rst) fm_rd_data <= '0;
      else if (fm_rd_en)
         for (int j = 0; j < KS; j++)
            fm_rd_data[j*DW +: DW] <= fm_val(int'(fm_rd_row) + j, int'(fm_rd_col));
   end

   always @(negedge clk) begin
      if (lb_enable) got_q.push_back('{lb_data_in, lb_mode, col_valid, col_last});
      if (fm_rd_en) rd_cnt <= rd_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
   end

   task automatic push_expected(input int k, input int w, input int h);
      beat_t b;
      for (int c = 0; c < w; c++) begin
         b = '0;
         for (int j = 1; j < k; j++) b.data[j*DW +: DW] = fm_val(j - 1, c);
         exp_q.push_back(b);
      end
      for (int r = k - 1; r < h; r++)
         for (int c = 0; c < w; c++) begin
            b = '0;
            b.data[0 +: DW] = fm_val(r, c);
            b.mode = 1'b1;
            b.cv   = 1'b1;
            b.cl   = (c == w - 1);
            exp_q.push_back(b);
         end
   endtask

   task automatic start_run(input int k, input int w, input int h);
      @(negedge clk);
      cfg_kernel_size = 3'(k);
      cfg_fm_width    = AW'(w);
      cfg_fm_height   = AW'(h);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (done) begin ok = 1'b1; break; end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; stall = 1'b0;
      cfg_kernel_size = '0; cfg_fm_width = '0; cfg_fm_height = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({fm_rd_en, fm_rd_row, fm_rd_col, lb_enable, lb_mode, lb_kernel_size, lb_depth,
           lb_data_in, col_valid, col_last, busy, done, cfg_err} !== '0) begin
         errors++;
         $display("FAIL reset_outputs busy=%b en=%b lb_en=%b depth=%0d data=%h want all 0",
                  busy, fm_rd_en, lb_enable, lb_depth, lb_data_in);
      end
`ifdef LB_FEEDER_STATS_EN
      checks++;
      if (stat_win_cnt !== 16'd0) begin
         errors++; $display("FAIL reset_stat got %0d want 0", stat_win_cnt);
      end
`endif
      rst = 1'b0;
   endtask

   task automatic test_k3_basic;
      int base = got_q.size();
      int d0 = done_cnt;
      bit ok;
      beat_t e;
      push_expected(3, 4, 4);
      start_run(3, 4, 4);
      wait_done(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL k3_done_timeout got none want done"); end
      for (int i = 0; exp_q.size() > 0; i++) begin
         e = exp_q.pop_front();
         checks++;
         if (base + i >= got_q.size()) begin
            errors++; $display("FAIL k3_beat%0d missing want %h", i, e);
         end else if (got_q[base+i] !== e) begin
            errors++; $display("FAIL k3_beat%0d got %h want %h", i, got_q[base+i], e);
         end
      end
      checks++;
      if (got_q.size() - base !== 12) begin
         errors++; $display("FAIL k3_beat_count got %0d want 12", got_q.size() - base);
      end
      checks++;
      if (done_cnt - d0 !== 1) begin
         errors++; $display("FAIL k3_done_pulses got %0d want 1", done_cnt - d0);
      end
      checks++;
      if ({lb_depth, lb_kernel_size, cfg_err, busy} !== {8'd3, 3'd3, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL k3_cfg_out got depth=%0d k=%0d err=%b busy=%b want 3 3 0 0",
                  lb_depth, lb_kernel_size, cfg_err, busy);
      end
   endtask

   task automatic test_k5_stats;
      int base = got_q.size();
      int ncv = 0;
      bit ok;
      beat_t e;
      push_expected(5, 8, 6);
      start_run(5, 8, 6);
      wait_done(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL k5_done_timeout got none want done"); end
      for (int i = 0; exp_q.size() > 0; i++) begin
         e = exp_q.pop_front();
         checks++;
         if (base + i >= got_q.size()) begin
            errors++; $display("FAIL k5_beat%0d missing want %h", i, e);
         end else if (got_q[base+i] !== e) begin
            errors++; $display("FAIL k5_beat%0d got %h want %h", i, got_q[base+i], e);
         end
      end
      for (int i = base; i < got_q.size(); i++) ncv += int'(got_q[i].cv);
      checks++;
      if (got_q.size() - base !== 24 || ncv !== 16) begin
         errors++;
         $display("FAIL k5_counts got beats=%0d cv=%0d want 24 16", got_q.size() - base, ncv);
      end
      checks++;
      if (lb_depth !== 8'd7 || lb_kernel_size !== 3'd5) begin
         errors++; $display("FAIL k5_cfg_out got depth=%0d k=%0d want 7 5", lb_depth, lb_kernel_size);
      end
`ifdef LB_FEEDER_STATS_EN
      checks++;
      if (stat_win_cnt !== 16'd16) begin
         errors++; $display("FAIL k5_stat got %0d want 16", stat_win_cnt);
      end
`endif
   endtask

   task automatic test_stall;
      int base = got_q.size();
      int n = 0;
      int nb = 0;
      int nr = 0;
      logic last_en;
      bit ok;
      beat_t e;
      push_expected(3, 8, 4);
      start_run(3, 8, 4);
      for (int i = 0; i < 200 && n < 11; i++) begin
         @(negedge clk);
         if (fm_rd_en) n++;
      end
      checks++;
      if (n < 11) begin errors++; $display("FAIL stall_reach got %0d reads want 11", n); end
      @(negedge clk);
      stall = 1'b1;
      #1;
      nb += int'(lb_enable); nr += int'(fm_rd_en);
      repeat (2) begin
         @(negedge clk);
         nb += int'(lb_enable); nr += int'(fm_rd_en);
      end
      last_en = lb_enable;
      @(negedge clk);
      stall = 1'b0;
      checks++;
      if (nb !== 2 || nr !== 0 || last_en !== 1'b0) begin
         errors++;
         $display("FAIL stall_window got beats=%0d reads=%0d last_en=%b want 2 0 0", nb, nr, last_en);
      end
      wait_done(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL stall_done_timeout got none want done"); end
      for (int i = 0; exp_q.size() > 0; i++) begin
         e = exp_q.pop_front();
         checks++;
         if (base + i >= got_q.size()) begin
            errors++; $display("FAIL stall_beat%0d missing want %h", i, e);
         end else if (got_q[base+i] !== e) begin
            errors++; $display("FAIL stall_beat%0d got %h want %h", i, got_q[base+i], e);
         end
      end
      checks++;
      if (got_q.size() - base !== 24) begin
         errors++; $display("FAIL stall_beat_count got %0d want 24", got_q.size() - base);
      end
   endtask

   task automatic test_cfg_err;
      int cfgs[2][3] = '{'{4, 4, 4}, '{3, 4, 2}};
      for (int t = 0; t < 2; t++) begin
         int r0 = rd_cnt;
         int b0 = got_q.size();
         int lat = 0;
         logic err_at_done = 1'b0;
         @(negedge clk);
         cfg_kernel_size = 3'(cfgs[t][0]);
         cfg_fm_width    = AW'(cfgs[t][1]);
         cfg_fm_height   = AW'(cfgs[t][2]);
         start = 1'b1;
         for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (done) begin lat = i; err_at_done = cfg_err; break; end
         end
         checks++;
         if (lat !== 2 || err_at_done !== 1'b1) begin
            errors++;
            $display("FAIL cfg_err%0d_done got lat=%0d err=%b want 2 1", t, lat, err_at_done);
         end
         repeat (3) @(negedge clk);
         @(posedge clk);
         #1;
         checks++;
         if (cfg_err !== 1'b1 || busy !== 1'b0 || rd_cnt - r0 !== 0 || got_q.size() - b0 !== 0) begin
            errors++;
            $display("FAIL cfg_err%0d_after got err=%b busy=%b reads=%0d beats=%0d want 1 0 0 0",
                     t, cfg_err, busy, rd_cnt - r0, got_q.size() - b0);
         end
      end
   endtask

   task automatic test_reset_midrun;
      int base;
      int d0;
      bit ok;
      beat_t e;
      push_expected(3, 4, 5);
      start_run(3, 4, 5);
      repeat (10) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || lb_mode !== 1'b1) begin
         errors++; $display("FAIL rst_mid_pre got busy=%b mode=%b want 1 1", busy, lb_mode);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({fm_rd_en, fm_rd_row, fm_rd_col, lb_enable, lb_mode, lb_kernel_size, lb_depth,
           lb_data_in, col_valid, col_last, busy, done, cfg_err} !== '0) begin
         errors++;
         $display("FAIL rst_mid_outputs busy=%b en=%b lb_en=%b mode=%b want all 0",
                  busy, fm_rd_en, lb_enable, lb_mode);
      end
      rst = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1;
      base = got_q.size();
      d0 = done_cnt;
      push_expected(3, 4, 5);
      start_run(3, 4, 5);
      wait_done(ok);
      checks++;
      if (!ok || done_cnt - d0 !== 1) begin
         errors++; $display("FAIL rst_rerun_done got ok=%b pulses=%0d want 1 1", ok, done_cnt - d0);
      end
      for (int i = 0; exp_q.size() > 0; i++) begin
         e = exp_q.pop_front();
         checks++;
         if (base + i >= got_q.size()) begin
            errors++; $display("FAIL rst_rerun_beat%0d missing want %h", i, e);
         end else if (got_q[base+i] !== e) begin
            errors++; $display("FAIL rst_rerun_beat%0d got %h want %h", i, got_q[base+i], e);
         end
      end
      checks++;
      if (got_q.size() - base !== 16) begin
         errors++; $display("FAIL rst_rerun_count got %0d want 16", got_q.size() - base);
      end
   endtask

   task automatic test_busy_start_w1;
      int base = got_q.size();
      int d0 = done_cnt;
      bit ok;
      beat_t e;
      push_expected(3, 1, 5);
      start_run(3, 1, 5);
      repeat (3) @(negedge clk);
      cfg_kernel_size = 3'd5;
      cfg_fm_width    = 8'd4;
      cfg_fm_height   = 8'd8;
      start = 1'b1;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL w1_busy got %b want 1", busy); end
      @(negedge clk);
      start = 1'b0;
      wait_done(ok);
      checks++;
      if (!ok || done_cnt - d0 !== 1) begin
         errors++; $display("FAIL w1_done got ok=%b pulses=%0d want 1 1", ok, done_cnt - d0);
      end
      for (int i = 0; exp_q.size() > 0; i++) begin
         e = exp_q.pop_front();
         checks++;
         if (base + i >= got_q.size()) begin
            errors++; $display("FAIL w1_beat%0d missing want %h", i, e);
         end else if (got_q[base+i] !== e) begin
            errors++; $display("FAIL w1_beat%0d got %h want %h", i, got_q[base+i], e);
         end
      end
      checks++;
      if (got_q.size() - base !== 4 || lb_depth !== 8'd0 || lb_kernel_size !== 3'd3) begin
         errors++;
         $display("FAIL w1_summary got beats=%0d depth=%0d k=%0d want 4 0 3",
                  got_q.size() - base, lb_depth, lb_kernel_size);
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      stall = 1'b0;
      test_reset();
      test_k3_basic();
      test_k5_stats();
      test_stall();
      test_cfg_err();
      test_reset_midrun();
      test_busy_start_w1();
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
